// File: rtl/gaplus_romloader.sv
// ROM download bus transmitter: byte stream in, paced ROMAD/ROMDT/ROMEN writes out, core held in reset until loaded.
// Optional trailer checksum (16-bit sum, low byte first) enabled by defining GAPLUS_ROMLOADER_CHECKSUM_EN.
module gaplus_romloader #(
    parameter int IMG_SIZE = 32'h20200,
    parameter int GAP      = 2
) (
    input  logic        ROMCL,
    input  logic        RESET,
    input  logic        DL_START,
    input  logic [7:0]  DL_DATA,
    input  logic        DL_VALID,
    output logic        DL_READY,
    output logic [17:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic        LOADED,
    output logic        DL_ERR,
    output logic        GAME_RST
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE, S_ERR} state_t;

    localparam logic [18:0] IMG_N   = 19'(IMG_SIZE);
    localparam logic [3:0]  GAP_V   = 4'(GAP);
    localparam logic [3:0]  GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit          HAS_GAP = (GAP != 0);

    state_t      r_state, w_next;
    logic [17:0] r_addr, r_romad;
    logic [18:0] r_cnt;
    logic [3:0]  r_gap;
    logic [7:0]  r_romdt;
    logic        r_romen, r_err;

    logic w_acc, w_data, w_fin_wait, w_img_end, w_bad, w_excess;

    // DL_START wins over a same-cycle byte
    assign w_acc    = DL_VALID && (r_state == S_LOAD) && !DL_START;
    assign w_data   = w_acc && (r_cnt < IMG_N);
    assign w_excess = DL_VALID && (r_state == S_DONE) && !DL_START;

`ifdef GAPLUS_ROMLOADER_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [7:0]  r_sum_lo;
    logic        w_trl_lo, w_trl_hi;

    assign w_trl_lo   = w_acc && (r_cnt == IMG_N);
    assign w_trl_hi   = w_acc && (r_cnt == IMG_N + 19'd1);
    assign w_bad      = w_trl_hi && ({DL_DATA, r_sum_lo} != r_sum);
    // the last data byte is paced like any other; the trailer decides DONE
    assign w_fin_wait = 1'b0;
    assign w_img_end  = 1'b0;

    always_ff @(posedge ROMCL or posedge RESET) begin
        if (RESET) begin
            r_sum    <= 16'd0;
            r_sum_lo <= 8'd0;
        end else if (DL_START) begin
            r_sum    <= 16'd0;
            r_sum_lo <= 8'd0;
        end else begin
            if (w_data)   r_sum    <= r_sum + {8'h00, DL_DATA};
            if (w_trl_lo) r_sum_lo <= DL_DATA;
        end
    end
`else
    assign w_bad      = 1'b0;
    // the final byte always passes through WAIT so DONE follows its strobe and gap
    assign w_fin_wait = w_data && (r_cnt == IMG_N - 19'd1);
    assign w_img_end  = (r_cnt == IMG_N);
`endif

    always_ff @(posedge ROMCL or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (DL_START) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_data && (HAS_GAP || w_fin_wait)) w_next = S_WAIT;
`ifdef GAPLUS_ROMLOADER_CHECKSUM_EN
                    if (w_trl_hi) w_next = w_bad ? S_ERR : S_DONE;
`endif
                end
                S_WAIT:  if (r_gap == 4'd0) w_next = w_img_end ? S_DONE : S_LOAD;
                S_DONE:  if (w_excess) w_next = S_ERR;
                default: w_next = r_state;
            endcase
        end
    end

    always_comb begin
        DL_READY = 1'b0;
        LOADED   = 1'b0;
        case (r_state)
            S_LOAD:  DL_READY = 1'b1;
            S_DONE:  LOADED   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ROMCL or posedge RESET) begin
        if (RESET) begin
            r_addr  <= 18'd0;
            r_cnt   <= 19'd0;
            r_gap   <= 4'd0;
            r_romad <= 18'd0;
            r_romdt <= 8'd0;
            r_romen <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_romen <= w_data;
            if (DL_START) begin
                r_addr <= 18'd0;
                r_cnt  <= 19'd0;
                r_gap  <= 4'd0;
                r_err  <= 1'b0;
            end else begin
                if (w_data) begin
                    r_romad <= r_addr;
                    r_romdt <= DL_DATA;
                    // saturate instead of wrapping past the top of the address space
                    if (r_addr != '1) r_addr <= r_addr + 18'd1;
                end
                if (w_acc) r_cnt <= r_cnt + 19'd1;
                if (w_data)
                    r_gap <= w_fin_wait ? GAP_V : GAP_M1;
                else if ((r_state == S_WAIT) && (r_gap != 4'd0))
                    r_gap <= r_gap - 4'd1;
                if (w_excess || w_bad) r_err <= 1'b1;
            end
        end
    end

    assign ROMAD    = r_romad;
    assign ROMDT    = r_romdt;
    assign ROMEN    = r_romen;
    assign DL_ERR   = r_err;
    assign GAME_RST = ~LOADED;
endmodule

// File: tb/tb_gaplus_romloader.sv
// Bench for gaplus_romloader: three instances with different size/gap, random bytes and valid pacing vs a stream model.
module tb_gaplus_romloader;
    localparam int N   = 3;
    localparam int SZ0 = 24, GP0 = 2;
    localparam int SZ1 = 4,  GP1 = 0;
    localparam int SZ2 = 3,  GP2 = 1;
`ifdef GAPLUS_ROMLOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct {
        int          k;
        int          cyc;
        logic [17:0] ad;
        logic [7:0]  dt;
        logic        rdy;
    } stb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [N];
    logic        valid [N];
    logic [7:0]  data  [N];
    logic        ready [N];
    logic [17:0] ad    [N];
    logic [7:0]  dt    [N];
    logic        en    [N];
    logic        loaded[N];
    logic        err   [N];
    logic        grst  [N];

    int   P_GP [N] = '{GP0, GP1, GP2};
    int   checks = 0, errors = 0, cyc = 0, dbl_en = 0;
    logic prev_en [N];
    stb_t mon_q[$], got[$], mon_s;
    logic [7:0] tx_q[$];

    gaplus_romloader #(.IMG_SIZE(SZ0), .GAP(GP0)) u_dut0 (
        .ROMCL(clk), .RESET(rst), .DL_START(start[0]), .DL_DATA(data[0]), .DL_VALID(valid[0]),
        .DL_READY(ready[0]), .ROMAD(ad[0]), .ROMDT(dt[0]), .ROMEN(en[0]),
        .LOADED(loaded[0]), .DL_ERR(err[0]), .GAME_RST(grst[0]));
    gaplus_romloader #(.IMG_SIZE(SZ1), .GAP(GP1)) u_dut1 (
        .ROMCL(clk), .RESET(rst), .DL_START(start[1]), .DL_DATA(data[1]), .DL_VALID(valid[1]),
        .DL_READY(ready[1]), .ROMAD(ad[1]), .ROMDT(dt[1]), .ROMEN(en[1]),
        .LOADED(loaded[1]), .DL_ERR(err[1]), .GAME_RST(grst[1]));
    gaplus_romloader #(.IMG_SIZE(SZ2), .GAP(GP2)) u_dut2 (
        .ROMCL(clk), .RESET(rst), .DL_START(start[2]), .DL_DATA(data[2]), .DL_VALID(valid[2]),
        .DL_READY(ready[2]), .ROMAD(ad[2]), .ROMDT(dt[2]), .ROMEN(en[2]),
        .LOADED(loaded[2]), .DL_ERR(err[2]), .GAME_RST(grst[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe log, plus back-to-back ROMEN detection for instances with a gap
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (en[k] === 1'b1) begin
                mon_s.k   = k;
                mon_s.cyc = cyc;
                mon_s.ad  = ad[k];
                mon_s.dt  = dt[k];
                mon_s.rdy = ready[k];
                mon_q.push_back(mon_s);
                if (prev_en[k] === 1'b1 && P_GP[k] != 0) dbl_en++;
            end
            prev_en[k] = en[k];
        end
    end

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        idle(1);
        start[k] = 1'b0;
    endtask

    // drive tx_q through the handshake; valid is randomly withheld when rnd=1
    task automatic send(input int k, input bit rnd, output int n_acc);
        int n;
        bit acc;
        n = 0;
        n_acc = 0;
        while (n_acc < tx_q.size() && n < 2000) begin
            valid[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            data[k]  = tx_q[n_acc];
            @(negedge clk);
            acc = valid[k] && ready[k];
            idle(1);
            if (acc) n_acc++;
            n++;
        end
        valid[k] = 1'b0;
    endtask

    task automatic collect(input int k);
        got.delete();
        foreach (mon_q[i]) if (mon_q[i].k == k) got.push_back(mon_q[i]);
    endtask

    function automatic logic [15:0] model_sum(input int n);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < n; i++) s = s + 16'(tx_q[i]);
        return s;
    endfunction

    task automatic add_trailer(input int sz, input bit good);
        logic [15:0] s;
        s = model_sum(sz) + (good ? 16'd0 : 16'd1);
        if (CK) begin
            tx_q.push_back(s[7:0]);
            tx_q.push_back(s[15:8]);
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < N; k++) begin
            start[k] = 1'b0; valid[k] = 1'b0; data[k] = 8'd0;
        end
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(10);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (grst[k] !== 1'b1 || ready[k] !== 1'b0 || en[k] !== 1'b0 || ad[k] !== 18'd0 ||
                dt[k] !== 8'd0 || loaded[k] !== 1'b0 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state k=%0d got grst=%b rdy=%b en=%b ad=%h dt=%h ld=%b err=%b need 1 0 0 0 0 0 0",
                         k, grst[k], ready[k], en[k], ad[k], dt[k], loaded[k], err[k]);
            end
        end
    endtask

    task automatic test_gap_pair;
        int n;
        mon_q.delete();
        pulse_start(0);
        tx_q = '{8'hA5, 8'h3C};
        send(0, 1'b0, n);
        idle(3);
        collect(0);
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL gap_pair_count got %0d strobes need 2", got.size());
        end else begin
            checks++;
            if (got[0].ad !== 18'd0 || got[0].dt !== 8'hA5 || got[1].ad !== 18'd1 || got[1].dt !== 8'h3C) begin
                errors++;
                $display("FAIL gap_pair_data got %h/%h %h/%h need 0/a5 1/3c", got[0].ad, got[0].dt, got[1].ad, got[1].dt);
            end
            checks++;
            if (got[1].cyc - got[0].cyc != GP0 + 1) begin
                errors++;
                $display("FAIL gap_pair_spacing got %0d need %0d", got[1].cyc - got[0].cyc, GP0 + 1);
            end
            checks++;
            if (got[0].rdy !== 1'b0) begin
                errors++;
                $display("FAIL gap_pair_ready got %b need 0", got[0].rdy);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        mon_q.delete();
        pulse_start(1);
        tx_q.delete();
        repeat (SZ1) tx_q.push_back(8'($urandom));
        add_trailer(SZ1, 1'b1);
        send(1, 1'b0, n);
        idle(4);
        collect(1);
        checks++;
        if (got.size() != SZ1) begin
            errors++;
            $display("FAIL b2b_count got %0d need %0d", got.size(), SZ1);
        end
        for (int i = 0; i < SZ1 && i < got.size(); i++) begin
            checks++;
            if (got[i].ad !== 18'(i) || got[i].dt !== tx_q[i] || got[i].cyc - got[0].cyc != i) begin
                errors++;
                $display("FAIL b2b_strobe[%0d] got ad=%h dt=%h dcyc=%0d need ad=%h dt=%h dcyc=%0d",
                         i, got[i].ad, got[i].dt, got[i].cyc - got[0].cyc, i, tx_q[i], i);
            end
        end
        checks++;
        if (loaded[1] !== 1'b1 || grst[1] !== 1'b0 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_loaded got ld=%b grst=%b err=%b need 1 0 0", loaded[1], grst[1], err[1]);
        end
        valid[1] = 1'b1;
        data[1]  = 8'($urandom);
        idle(1);
        valid[1] = 1'b0;
        idle(2);
        collect(1);
        checks++;
        if (got.size() != SZ1 || err[1] !== 1'b1 || loaded[1] !== 1'b0 || grst[1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_excess got strobes=%0d err=%b ld=%b grst=%b need %0d 1 0 1",
                     got.size(), err[1], loaded[1], grst[1], SZ1);
        end
    endtask

    task automatic test_restart;
        int n;
        pulse_start(1);
        tx_q.delete();
        repeat (2) tx_q.push_back(8'($urandom));
        send(1, 1'b1, n);
        idle(2);
        checks++;
        if (err[1] !== 1'b0 || loaded[1] !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear got err=%b ld=%b need 0 0", err[1], loaded[1]);
        end
        tx_q.delete();
        repeat (SZ1) tx_q.push_back(8'($urandom));
        add_trailer(SZ1, 1'b1);
        mon_q.delete();
        // a byte offered with the start pulse must be dropped
        data[1]  = ~tx_q[0];
        valid[1] = 1'b1;
        start[1] = 1'b1;
        idle(1);
        start[1] = 1'b0;
        valid[1] = 1'b0;
        checks++;
        if (loaded[1] !== 1'b0) begin
            errors++;
            $display("FAIL restart_loaded got %b need 0", loaded[1]);
        end
        send(1, 1'b1, n);
        idle(4);
        collect(1);
        checks++;
        if (got.size() != SZ1) begin
            errors++;
            $display("FAIL restart_count got %0d need %0d", got.size(), SZ1);
        end
        for (int i = 0; i < SZ1 && i < got.size(); i++) begin
            checks++;
            if (got[i].ad !== 18'(i) || got[i].dt !== tx_q[i]) begin
                errors++;
                $display("FAIL restart_strobe[%0d] got ad=%h dt=%h need ad=%h dt=%h", i, got[i].ad, got[i].dt, i, tx_q[i]);
            end
        end
        checks++;
        if (loaded[1] !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got ld=%b need 1", loaded[1]);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        pulse_start(0);
        tx_q.delete();
        repeat (18) tx_q.push_back(8'($urandom));
        send(0, 1'b1, n);
        checks++;
        if (en[0] !== 1'b1 || ad[0] !== 18'd17 || dt[0] !== tx_q[17]) begin
            errors++;
            $display("FAIL midrst_pre got en=%b ad=%h dt=%h need 1 11 %h", en[0], ad[0], dt[0], tx_q[17]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (en[0] !== 1'b0 || ad[0] !== 18'd0 || dt[0] !== 8'd0 || ready[0] !== 1'b0 ||
            grst[0] !== 1'b1 || loaded[0] !== 1'b0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got en=%b ad=%h dt=%h rdy=%b grst=%b ld=%b err=%b need 0 0 0 0 1 0 0",
                     en[0], ad[0], dt[0], ready[0], grst[0], loaded[0], err[0]);
        end
        idle(1);
        rst = 1'b0;
        mon_q.delete();
        pulse_start(0);
        tx_q = '{8'($urandom)};
        send(0, 1'b0, n);
        idle(3);
        collect(0);
        checks++;
        if (got.size() != 1 || got[0].ad !== 18'd0 || got[0].dt !== tx_q[0]) begin
            errors++;
            $display("FAIL midrst_restart got n=%0d ad=%h dt=%h need 1 0 %h",
                     got.size(), (got.size() > 0) ? got[0].ad : 18'h0, (got.size() > 0) ? got[0].dt : 8'h0, tx_q[0]);
        end
    endtask

    task automatic test_full_load;
        int n;
        mon_q.delete();
        pulse_start(0);
        tx_q.delete();
        repeat (SZ0) tx_q.push_back(8'($urandom));
        add_trailer(SZ0, 1'b1);
        send(0, 1'b1, n);
        checks++;
        if (n != tx_q.size()) begin
            errors++;
            $display("FAIL full_accept got %0d need %0d", n, tx_q.size());
        end
        idle(8);
        collect(0);
        checks++;
        if (got.size() != SZ0) begin
            errors++;
            $display("FAIL full_count got %0d need %0d", got.size(), SZ0);
        end
        for (int i = 0; i < SZ0 && i < got.size(); i++) begin
            checks++;
            if (got[i].ad !== 18'(i) || got[i].dt !== tx_q[i] || (i > 0 && got[i].cyc - got[i-1].cyc < GP0 + 1)) begin
                errors++;
                $display("FAIL full_strobe[%0d] got ad=%h dt=%h need ad=%h dt=%h spacing>=%0d",
                         i, got[i].ad, got[i].dt, i, tx_q[i], GP0 + 1);
            end
        end
        checks++;
        if (loaded[0] !== 1'b1 || grst[0] !== 1'b0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_loaded got ld=%b grst=%b err=%b need 1 0 0", loaded[0], grst[0], err[0]);
        end
    endtask

    task automatic test_checksum;
        int n;
        bit exp_ld;
        for (int run = 0; run < 3; run++) begin
            mon_q.delete();
            pulse_start(2);
            tx_q.delete();
            if (run < 2) begin
                tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
            end else begin
                repeat (SZ2) tx_q.push_back(8'($urandom));
            end
            add_trailer(SZ2, run != 1);
            exp_ld = !CK || (run != 1);
            send(2, run == 2, n);
            idle(6);
            collect(2);
            checks++;
            if (n != tx_q.size() || got.size() != SZ2) begin
                errors++;
                $display("FAIL cksum_count run=%0d got acc=%0d strobes=%0d need %0d %0d", run, n, got.size(), tx_q.size(), SZ2);
            end
            for (int i = 0; i < SZ2 && i < got.size(); i++) begin
                checks++;
                if (got[i].ad !== 18'(i) || got[i].dt !== tx_q[i]) begin
                    errors++;
                    $display("FAIL cksum_strobe run=%0d [%0d] got ad=%h dt=%h need ad=%h dt=%h",
                             run, i, got[i].ad, got[i].dt, i, tx_q[i]);
                end
            end
            checks++;
            if (loaded[2] !== exp_ld || err[2] !== !exp_ld || grst[2] !== !exp_ld) begin
                errors++;
                $display("FAIL cksum_result run=%0d got ld=%b err=%b grst=%b need %b %b %b",
                         run, loaded[2], err[2], grst[2], exp_ld, !exp_ld, !exp_ld);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gap_pair();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_full_load();
        test_checksum();
        checks++;
        if (dbl_en != 0) begin
            errors++;
            $display("FAIL romen_consecutive got %0d occurrences need 0", dbl_en);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gaplus_romloader.md
Name: gaplus_romloader

Overview:
- Transmitter side of the ROM download bus (ROMCL/ROMAD/ROMDT/ROMEN) that the sound, video and CPU ROM images decode by address region.
- Accepts a byte stream from the host/SD loader through a valid/ready handshake and assigns sequential 18-bit addresses.
- Issues one-cycle ROMEN write strobes, paced so slow DLROM write ports are never overrun.
- Holds the game core in reset until the image is complete and, optionally, verified.

Parameters:
- IMG_SIZE, 18'h20200, total image bytes; the last address is IMG_SIZE-1.
- GAP, 2, idle cycles inserted after every ROMEN strobe; 0..15.

Ports:
- ROMCL    input   1   download clock; drives the whole block and is forwarded unchanged to the ROM consumers.
- RESET    input   1   asynchronous, active-high reset.
- DL_START input   1   one-cycle pulse; starts a new download and clears the address, byte count and sum.
- DL_DATA  input   8   image byte.
- DL_VALID input   1   DL_DATA is valid.
- DL_READY output  1   block accepts a byte this cycle.
- ROMAD    output  18  write address.
- ROMDT    output  8   write data.
- ROMEN    output  1   write strobe; one cycle per byte.
- LOADED   output  1   image complete (and verified when the optional check is compiled in).
- DL_ERR   output  1   sticky error flag.
- GAME_RST output  1   core reset; equals ~LOADED.

Behaviour:
- Reset values:
  - State IDLE.
  - ROMAD=0, ROMDT=0, ROMEN=0.
  - DL_READY=0, LOADED=0, DL_ERR=0, GAME_RST=1.
  - Internal byte count and gap counter are 0.
- States: IDLE, LOAD, WAIT, DONE, ERR.
- IDLE:
  - DL_READY=0.
  - DL_START moves to LOAD and clears the address, count and sum.
- LOAD:
  - DL_READY=1.
  - A byte is accepted in a cycle where DL_VALID and DL_READY are both high.
  - On the next cycle ROMEN=1, ROMDT=byte and ROMAD=the current address. This is 1-cycle latency; ROMAD and ROMDT are registered.
  - The address increments after the strobe.
  - If GAP>0, the block enters WAIT for GAP cycles with DL_READY=0 and then returns to LOAD.
  - If GAP=0, DL_READY stays 1 and a back-to-back byte per cycle is allowed.
- Completion:
  - When the accepted count reaches IMG_SIZE, the block goes to DONE after the final strobe and any gap.
  - In DONE: DL_READY=0 and LOADED=1.
- Excess data:
  - DL_VALID while in DONE is ignored; no strobe is generated.
  - DL_ERR is set sticky and the block goes to ERR.
  - ERR holds DL_READY=0 and LOADED=0.
- DL_START in any state:
  - Takes priority over a same-cycle DL_VALID.
  - Restarts in LOAD and clears LOADED.
  - DL_ERR is cleared only by DL_START or RESET.
- ROMAD and ROMDT hold their last values between strobes. ROMEN is never high for two consecutive cycles unless GAP=0.
- Address arithmetic:
  - 18-bit, no wrap.
  - IMG_SIZE must not exceed 2^18; address 18'h3FFFF is the last possible one.
- Reset mid-download: all state returns to reset values; the partial image is not marked loaded.
- GAME_RST is combinational ~LOADED, so the core is released in the same cycle LOADED rises.

Optional Feature:
- Macro: GAPLUS_ROMLOADER_CHECKSUM_EN.
- With the macro:
  - A 16-bit modular sum of all accepted bytes is accumulated.
  - After the last data byte, the next two accepted bytes are the expected sum, low byte then high byte. These bytes produce no ROMEN.
  - On a match the block enters DONE.
  - On a mismatch it sets DL_ERR and goes to ERR; LOADED stays 0.
  - The total stream is IMG_SIZE+2 bytes.
- Without the macro: no sum logic; the stream is exactly IMG_SIZE bytes and DONE is entered as described above.

Test Plan:
- Reset, then idle 10 cycles -> GAME_RST=1, DL_READY=0, ROMEN=0, ROMAD=0.
- DL_START, then bytes 8'hA5 and 8'h3C with DL_VALID held high, GAP=2 -> ROMEN pulses at AD=0 DT=A5 and AD=1 DT=3C, separated by 2 idle cycles with DL_READY=0.
- IMG_SIZE=4, GAP=0, 4 bytes on consecutive cycles -> 4 consecutive ROMEN strobes at AD 0..3; LOADED=1 and GAP is satisfied; a 5th DL_VALID sets DL_ERR=1 with no strobe.
- DL_START pulsed after 2 of 4 bytes -> LOADED=0, address restarts at 0; the next byte is written at AD=0.
- RESET asserted mid-LOAD at AD=17 -> all outputs return to reset values immediately (asynchronously); the next DL_START begins at AD=0.
- CHECKSUM_EN, IMG_SIZE=3, bytes 01 02 03 then 06 00 -> 3 strobes, LOADED=1; the same stream with trailer 07 00 -> DL_ERR=1, LOADED=0, GAME_RST=1.
